// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the restoring-division controller: state encoding,
// default quotient width and the width of the iteration index.
package div_ctrl_pkg;

    localparam int unsigned ANCHO_DEF = 16;

    typedef enum logic [3:0] {
        StInicio,
        StCarga,
        StAbs,
        StDesplaza,
        StResta,
        StEvalua,
        StCorrige,
        StFin,
        StError
    } estado_e;

    // Registered strobes; restaurar/fijar_q0 are derived from evalua and a_negativo.
    typedef struct packed {
        logic cargar;
        logic complementar_a;
        logic complementar_b;
        logic desplazar;
        logic restar;
        logic evalua;
        logic corregir_q;
        logic corregir_r;
        logic listo;
        logic error_div0;
        logic ocupado;
    } salidas_t;

    function automatic int unsigned ancho_cuenta(input int unsigned ancho);
        return $clog2(ancho) + 1;
    endfunction

endpackage

// File: rtl/controlador_division_if.sv
// Host/datapath handshake bundle of the division controller.
interface controlador_division_if
    import div_ctrl_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
) ();

    localparam int unsigned AnchoCuenta = ancho_cuenta(ANCHO);

    logic go;
    logic neg1;
    logic neg2;
    logic b_es_cero;
    logic a_negativo;
    logic cargar;
    logic complementar_a;
    logic complementar_b;
    logic desplazar;
    logic restar;
    logic restaurar;
    logic fijar_q0;
    logic corregir_q;
    logic corregir_r;
    logic listo;
    logic error_div0;
    logic ocupado;
    logic [AnchoCuenta-1:0] cuenta;

    modport master (
        output go, neg1, neg2, b_es_cero, a_negativo,
        input  cargar, complementar_a, complementar_b, desplazar, restar, restaurar,
               fijar_q0, corregir_q, corregir_r, listo, error_div0, ocupado, cuenta
    );

    modport slave (
        input  go, neg1, neg2, b_es_cero, a_negativo,
        output cargar, complementar_a, complementar_b, desplazar, restar, restaurar,
               fijar_q0, corregir_q, corregir_r, listo, error_div0, ocupado, cuenta
    );

endinterface

// File: rtl/contador_iteraciones.sv
// Iteration index of the division loop: synchronous clear, increment and a
// terminal flag raised on the last iteration (cuenta == ANCHO-1).
module contador_iteraciones
    import div_ctrl_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF,
    localparam int unsigned AnchoCuenta = ancho_cuenta(ANCHO)
) (
    input  logic                   reloj,
    input  logic                   reset,
    input  logic                   limpiar_i,
    input  logic                   incrementar_i,
    output logic [AnchoCuenta-1:0] cuenta_o,
    output logic                   terminal_o
);

    logic [AnchoCuenta-1:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (limpiar_i) begin
            cuenta_d = '0;
        end else if (incrementar_i) begin
            cuenta_d = cuenta_q + AnchoCuenta'(1);
        end
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta_o   = cuenta_q;
    assign terminal_o = (cuenta_q == AnchoCuenta'(ANCHO - 1));

endmodule

// File: rtl/controlador_division.sv
// Shift/subtract division controller. Define DIV_SIGNO_EN to include the
// ABS and CORRIGE steps for signed operands.
module controlador_division
    import div_ctrl_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
) (
    input logic                   reloj,
    input logic                   reset,
    controlador_division_if.slave bus
);

    estado_e  estado_q, estado_d;
    logic     neg1_q, neg1_d, neg2_q, neg2_d;
    salidas_t sal_q, sal_d;
    logic     terminal;

    always_comb begin
        estado_d = estado_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        case (estado_q)
            StInicio: begin
                if (bus.go) begin
                    estado_d = StCarga;
`ifdef DIV_SIGNO_EN
                    neg1_d   = bus.neg1;
                    neg2_d   = bus.neg2;
`else
                    neg1_d   = 1'b0;
                    neg2_d   = 1'b0;
`endif
                end
            end
`ifdef DIV_SIGNO_EN
            StCarga:    estado_d = bus.b_es_cero ? StError : StAbs;
            StAbs:      estado_d = StDesplaza;
            StEvalua:   estado_d = terminal ? StCorrige : StDesplaza;
            StCorrige:  estado_d = StFin;
`else
            StCarga:    estado_d = bus.b_es_cero ? StError : StDesplaza;
            StEvalua:   estado_d = terminal ? StFin : StDesplaza;
`endif
            StDesplaza: estado_d = StResta;
            StResta:    estado_d = StEvalua;
            StFin:      estado_d = StInicio;
            StError:    estado_d = StInicio;
            default:    estado_d = StInicio;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        sal_d         = '0;
        sal_d.ocupado = (estado_d != StInicio);
        case (estado_d)
            StCarga:    sal_d.cargar = 1'b1;
`ifdef DIV_SIGNO_EN
            StAbs: begin
                sal_d.complementar_a = neg1_d;
                sal_d.complementar_b = neg2_d;
            end
            StCorrige: begin
                sal_d.corregir_q = neg1_d ^ neg2_d;
                sal_d.corregir_r = neg1_d;
            end
`endif
            StDesplaza: sal_d.desplazar = 1'b1;
            StResta:    sal_d.restar    = 1'b1;
            StEvalua:   sal_d.evalua    = 1'b1;
            StFin:      sal_d.listo     = 1'b1;
            StError: begin
                sal_d.listo      = 1'b1;
                sal_d.error_div0 = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            estado_q <= StInicio;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            sal_q    <= '0;
        end else begin
            estado_q <= estado_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            sal_q    <= sal_d;
        end
    end

    contador_iteraciones #(
        .ANCHO(ANCHO)
    ) u_contador (
        .reloj        (reloj),
        .reset        (reset),
        .limpiar_i    ((estado_q == StFin) || (estado_q == StError)),
        .incrementar_i(estado_q == StEvalua),
        .cuenta_o     (bus.cuenta),
        .terminal_o   (terminal)
    );

    assign bus.cargar         = sal_q.cargar;
    assign bus.complementar_a = sal_q.complementar_a;
    assign bus.complementar_b = sal_q.complementar_b;
    assign bus.desplazar      = sal_q.desplazar;
    assign bus.restar         = sal_q.restar;
    // The remainder sign is only known inside EVALUA, so this pair is not registered.
    assign bus.restaurar      = sal_q.evalua & bus.a_negativo;
    assign bus.fijar_q0       = sal_q.evalua & ~bus.a_negativo;
    assign bus.corregir_q     = sal_q.corregir_q;
    assign bus.corregir_r     = sal_q.corregir_r;
    assign bus.listo          = sal_q.listo;
    assign bus.error_div0     = sal_q.error_div0;
    assign bus.ocupado        = sal_q.ocupado;

endmodule

// File: tb/tb_controlador_division.sv
// Directed self-checking bench for controlador_division (signed or unsigned build).
module tb_controlador_division;
    import div_ctrl_pkg::*;

    localparam int A = 16;
`ifdef DIV_SIGNO_EN
    localparam bit Signo = 1'b1;
`else
    localparam bit Signo = 1'b0;
`endif
    localparam int Primero = Signo ? 3 : 2;  // cycle of the first DESPLAZA
    localparam int Lat     = Signo ? 3 * A + 4 : 3 * A + 2;

    logic reloj = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    controlador_division_if #(.ANCHO(A)) bus ();

    controlador_division #(
        .ANCHO(A)
    ) dut (
        .reloj(reloj),
        .reset(reset),
        .bus  (bus)
    );

    always #5 reloj = ~reloj;

    function automatic logic [11:0] salidas();
        return {bus.cargar, bus.complementar_a, bus.complementar_b, bus.desplazar, bus.restar,
                bus.restaurar, bus.fijar_q0, bus.corregir_q, bus.corregir_r, bus.listo,
                bus.error_div0, bus.ocupado};
    endfunction

    // Expected output vector k cycles after the go-sampling edge.
    function automatic logic [11:0] esperado(input int k, input bit n1, input bit n2,
                                             input bit an);
        logic [11:0] v;
        v = '0;
        if (k < 1 || k > Lat) return v;
        v[0] = 1'b1;
        if (k == 1) v[11] = 1'b1;
        if (Signo && k == 2) begin
            v[10] = n1;
            v[9]  = n2;
        end
        if (k >= Primero && k < Primero + 3 * A) begin
            case ((k - Primero) % 3)
                0:       v[8] = 1'b1;
                1:       v[7] = 1'b1;
                default: if (an) v[6] = 1'b1; else v[5] = 1'b1;
            endcase
        end
        if (Signo && k == Primero + 3 * A) begin
            v[4] = n1 ^ n2;
            v[3] = n1;
        end
        if (k == Lat) v[2] = 1'b1;
        return v;
    endfunction

    function automatic int cuenta_esp(input int k);
        if (k < Primero || k > Lat) return 0;
        if (k < Primero + 3 * A) return (k - Primero) / 3;
        return A;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller has already driven go=1 (and signs) before the upcoming edge.
    task automatic run_op(input bit n1, input bit n2, input bit pat, input bit mantener);
        int pulsos;
        bit an;
        pulsos = 0;
        @(posedge reloj);
        for (int k = 1; k <= Lat + 1; k++) begin
            @(negedge reloj);
            if (!mantener) bus.go = 1'b0;
            an = 1'b0;
            if (k >= Primero && k < Primero + 3 * A && (k - Primero) % 3 == 2)
                an = (((k - Primero) / 3) % 2 == 1) ^ pat;
            bus.a_negativo = an;
            #1;
            check($sformatf("salidas k=%0d", k), {4'h0, salidas()}, {4'h0, esperado(k, n1, n2, an)});
            check($sformatf("cuenta k=%0d", k), 16'(bus.cuenta), 16'(cuenta_esp(k)));
            if (bus.restaurar || bus.fijar_q0) pulsos++;
        end
        bus.a_negativo = 1'b0;
        check("strobes evalua", 16'(pulsos), 16'(A));
    endtask

    initial begin
        int extra;
        bus.go         = 1'b0;
        bus.neg1       = 1'b0;
        bus.neg2       = 1'b0;
        bus.b_es_cero  = 1'b0;
        bus.a_negativo = 1'b0;

        #2;
        check("reset salidas", {4'h0, salidas()}, 16'h0);
        check("reset cuenta", 16'(bus.cuenta), 16'h0);
        #20;
        @(negedge reloj);
        reset = 1'b1;
        repeat (3) @(negedge reloj);
        #1;
        check("reposo", {4'h0, salidas()}, 16'h0);

        // Three single operations with different sign/remainder patterns.
        @(negedge reloj);
        bus.go = 1'b1; bus.neg1 = 1'b1; bus.neg2 = 1'b0;
        run_op(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge reloj);
        bus.go = 1'b1; bus.neg1 = 1'b0; bus.neg2 = 1'b1;
        run_op(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge reloj);
        bus.go = 1'b1; bus.neg1 = 1'b1; bus.neg2 = 1'b1;
        run_op(1'b1, 1'b1, 1'b0, 1'b0);

        // Divide by zero.
        @(negedge reloj);
        bus.go = 1'b1; bus.neg1 = 1'b0; bus.neg2 = 1'b0; bus.b_es_cero = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        bus.go = 1'b0;
        #1;
        check("div0 carga", {4'h0, salidas()}, 16'h801);
        @(negedge reloj);
        bus.b_es_cero = 1'b0;
        #1;
        check("div0 error", {4'h0, salidas()}, 16'h007);
        @(negedge reloj);
        #1;
        check("div0 inicio", {4'h0, salidas()}, 16'h0);

        // Reset in the middle of iteration 5, then a full operation.
        @(negedge reloj);
        bus.go = 1'b1; bus.neg1 = 1'b1; bus.neg2 = 1'b1;
        @(posedge reloj);
        for (int k = 1; k <= Primero + 15; k++) begin
            @(negedge reloj);
            bus.go = 1'b0;
        end
        #1;
        check("antes abort cuenta", 16'(bus.cuenta), 16'd5);
        #1;
        reset = 1'b0;
        #1;
        check("abort salidas", {4'h0, salidas()}, 16'h0);
        check("abort cuenta", 16'(bus.cuenta), 16'h0);
        repeat (3) @(negedge reloj);
        #1;
        check("abort sin listo", {4'h0, salidas()}, 16'h0);
        @(negedge reloj);
        reset = 1'b1;
        @(negedge reloj);
        bus.go = 1'b1; bus.neg1 = 1'b0; bus.neg2 = 1'b0;
        run_op(1'b0, 1'b0, 1'b1, 1'b0);

        // go held high for 120 cycles: two full operations back to back.
        @(negedge reloj);
        bus.go = 1'b1; bus.neg1 = 1'b0; bus.neg2 = 1'b1;
        run_op(1'b0, 1'b1, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 1'b1, 1'b1);
        extra = 0;
        for (int i = 0; i < 120 - 2 * (Lat + 1); i++) begin
            @(negedge reloj);
            #1;
            if (bus.listo) extra++;
        end
        check("listo extra", 16'(extra), 16'h0);
        check("tercera en curso", {15'h0, bus.ocupado}, 16'h1);
        @(negedge reloj);
        bus.go = 1'b0;
        reset  = 1'b0;
        #1;
        check("reset final", {4'h0, salidas()}, 16'h0);
        @(negedge reloj);
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
